// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_ctrl
// Purpose  : Main control FSM for the multicycle MIPS datapath. Sequences
//            fetch / decode / execute / memory / writeback for R_TYPE, ADDI,
//            LW, SW, BEQ and J over one shared memory port and one shared
//            ALU. Drives every datapath mux select and write enable, owns the
//            req/ready handshake to unified memory, counts retired
//            instructions and flags memory timeouts.
// Ports    : clk, rst (async, active high), run (allow new fetches),
//            opcode (IR[31:26]), mem_ready (memory completes access)
//            mem_req/mem_we/iord             - memory access control
//            ir_write/pc_write/pc_write_cond - architectural register loads
//            pc_src/alu_src_a/alu_src_b/alu_op - datapath mux / ALU control
//            reg_write/reg_dst/mem_to_reg    - register file writeback
//            instr_done/illegal_op/bus_err   - single-cycle event pulses
//            retired                          - retired instruction count
//            state_dbg                        - current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  // Wide enough to hold MEM_TIMEOUT-1 even when MEM_TIMEOUT is 1.
  localparam int TO_W = $clog2(MEM_TIMEOUT) + 1;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;

  localparam logic [TO_W-1:0] c_to_last = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC    = 4'd6,
    S_ALU_WB  = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [TO_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]  r_retired;
  logic              w_wait;
  logic              w_timeout;

  // A cycle counts as "waiting" only when a request is outstanding and the
  // memory has not answered. FETCH with run=0 issues no request.
  always_comb begin
    w_wait = 1'b0;
    case (r_state)
      S_FETCH:            w_wait = run & ~mem_ready;
      S_MEM_RD, S_MEM_WR: w_wait = ~mem_ready;
      default:            w_wait = 1'b0;
    endcase
  end

  // The current waiting cycle is the MEM_TIMEOUT-th one. A mem_ready in the
  // same cycle clears w_wait, so a late completion beats the timeout.
  assign w_timeout = w_wait && (r_wait_cnt == c_to_last);

  always_comb begin
    w_next        = r_state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC+4 is formed on the ALU while the instruction is read.
        mem_req   = run;
        alu_src_b = 2'b01;
        if (run && mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut speculatively.
        alu_src_b = 2'b11;
        case (opcode)
          c_op_lw, c_op_sw: w_next = S_MEM_ADR;
          c_op_rtype:       w_next = S_EXEC;
          c_op_beq:         w_next = S_BRANCH;
          c_op_addi:        w_next = S_ADDI_EX;
          c_op_j:           w_next = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == c_op_lw) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready)      w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end else if (w_timeout) begin
          w_next = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        instr_done    = 1'b1;
        w_next        = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase

    // While reset is held the state is forced to FETCH, but the handshake
    // driven terms must not reach the datapath.
    if (rst) begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign bus_err = w_timeout & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_retired  <= '0;
    end else begin
      r_state <= w_next;
      // Any non-waiting cycle (completion, state change, idle) or a timeout
      // zeroes the counter, so every memory state is entered with it clear.
      if (w_wait && !w_timeout) r_wait_cnt <= r_wait_cnt + TO_W'(1);
      else                      r_wait_cnt <= '0;
      if (instr_done) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign retired   = r_retired;
  assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc_ctrl
// Purpose  : Self-checking bench for mips_mc_ctrl. Instructions are expanded
//            into an expected per-cycle trace (state visited, inputs applied,
//            pulses expected) from the instruction-level rules, then played
//            against the DUT cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_ctrl;
  localparam int CNT_W = 4;
  localparam int TO    = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  logic clk = 1'b0;
  logic rst, run, mem_ready;
  logic [5:0] opcode;
  logic mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic alu_src_a, reg_write, reg_dst, mem_to_reg;
  logic instr_done, illegal_op, bus_err;
  logic [CNT_W-1:0] retired;
  logic [3:0] state_dbg;
  logic [16:0] ctrl_vec;

  mips_mc_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .instr_done(instr_done), .illegal_op(illegal_op), .bus_err(bus_err),
    .retired(retired), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign ctrl_vec = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
                     pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
                     mem_to_reg};

  typedef struct {
    logic [3:0] st;
    logic       run;
    logic       rdy;
    logic [5:0] op;
    logic       done;
    logic       ill;
    logic       berr;
  } cyc_t;

  cyc_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_ret = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected control word for a state, taken from the per-state output list.
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic r,
                                           input logic rdy, input logic in_rst);
    logic mreq, mwe, io, irw, pcw, pcwc, asa, rw, rd, m2r;
    logic [1:0] pcs, asb, aop;
    {mreq, mwe, io, irw, pcw, pcwc, asa, rw, rd, m2r} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      4'd0:  begin mreq = r; asb = 2'b01; irw = r & rdy & ~in_rst; pcw = irw; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  begin mreq = 1'b1; io = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mreq = 1'b1; mwe = 1'b1; io = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rw = 1'b1; rd = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      4'd9:  begin asa = 1'b1; asb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin pcw = 1'b1; pcs = 2'b10; end
      default: ;
    endcase
    return {mreq, mwe, io, irw, pcw, pcwc, pcs, asa, asb, aop, rw, rd, m2r};
  endfunction

  task automatic push(input logic [3:0] st, input logic r, input logic rdy,
                      input logic [5:0] op, input logic d, input logic il,
                      input logic be);
    cyc_t c;
    c.st = st; c.run = r; c.rdy = rdy; c.op = op;
    c.done = d; c.ill = il; c.berr = be;
    q.push_back(c);
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Expand one instruction: idle = FETCH cycles with run=0, fd/md = cycles
  // the memory withholds ready during fetch / data access.
  task automatic gen(input logic [5:0] op, input int idle, input int fd, input int md);
    logic [3:0] mst;
    for (int i = 0; i < idle; i++) push(4'd0, 1'b0, rb(), op, 1'b0, 1'b0, 1'b0);
    if (fd >= TO) begin
      for (int i = 0; i < TO; i++) push(4'd0, 1'b1, 1'b0, op, 1'b0, 1'b0, i == TO-1);
      return;
    end
    for (int i = 0; i < fd; i++) push(4'd0, 1'b1, 1'b0, op, 1'b0, 1'b0, 1'b0);
    push(4'd0, 1'b1, 1'b1, op, 1'b0, 1'b0, 1'b0);
    if (!(op inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW})) begin
      push(4'd1, rb(), rb(), op, 1'b0, 1'b1, 1'b0);
      return;
    end
    push(4'd1, rb(), rb(), op, 1'b0, 1'b0, 1'b0);
    case (op)
      OP_R:    begin push(4'd6, rb(), rb(), op, 0, 0, 0); push(4'd7, rb(), rb(), op, 1, 0, 0); end
      OP_ADDI: begin push(4'd9, rb(), rb(), op, 0, 0, 0); push(4'd10, rb(), rb(), op, 1, 0, 0); end
      OP_BEQ:  push(4'd8, rb(), rb(), op, 1, 0, 0);
      OP_J:    push(4'd11, rb(), rb(), op, 1, 0, 0);
      default: begin
        push(4'd2, rb(), rb(), op, 0, 0, 0);
        mst = (op == OP_LW) ? 4'd3 : 4'd5;
        if (md >= TO) begin
          for (int i = 0; i < TO; i++) push(mst, rb(), 1'b0, op, 1'b0, 1'b0, i == TO-1);
        end else begin
          for (int i = 0; i < md; i++) push(mst, rb(), 1'b0, op, 1'b0, 1'b0, 1'b0);
          if (op == OP_LW) begin
            push(4'd3, rb(), 1'b1, op, 0, 0, 0);
            push(4'd4, rb(), rb(), op, 1, 0, 0);
          end else begin
            push(4'd5, rb(), 1'b1, op, 1, 0, 0);
          end
        end
      end
    endcase
  endtask

  // Entered and left just after a rising edge.
  task automatic run_q(input int max_cyc);
    cyc_t c;
    int k = 0;
    while (q.size() > 0 && k < max_cyc) begin
      c = q.pop_front();
      k++;
      run = c.run; mem_ready = c.rdy; opcode = c.op;
      @(negedge clk);
      chk("state", 32'(state_dbg), 32'(c.st));
      chk("ctrl", 32'(ctrl_vec), 32'(exp_ctrl(c.st, c.run, c.rdy, 1'b0)));
      chk("pulses", 32'({instr_done, illegal_op, bus_err}), 32'({c.done, c.ill, c.berr}));
      chk("retired", 32'(retired), 32'(model_ret));
      @(posedge clk); #1;
      if (c.done) model_ret = (model_ret + 1) % (1 << CNT_W);
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] o;
    case ($urandom_range(0, 6))
      0: o = OP_R;   1: o = OP_ADDI; 2: o = OP_LW; 3: o = OP_SW;
      4: o = OP_BEQ; 5: o = OP_J;
      default: begin
        o = 6'($urandom);
        while (o inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW}) o = 6'($urandom);
      end
    endcase
    return o;
  endfunction

  function automatic int pick_delay();
    return ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 5));
  endfunction

  initial begin
    rst = 1'b1; run = 1'b1; mem_ready = 1'b1; opcode = OP_R;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_ctrl", 32'(ctrl_vec), 32'(exp_ctrl(4'd0, 1'b1, 1'b1, 1'b1)));
    chk("rst_pulses", 32'({instr_done, illegal_op, bus_err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // R_TYPE, no memory stalls
    gen(OP_R, 0, 0, 0); run_q(1000);
    chk("ret_after_r", 32'(retired), 32'd1);
    // LW with three stalled data cycles
    gen(OP_LW, 0, 0, 3); run_q(1000);
    // BEQ then J
    gen(OP_BEQ, 0, 0, 0); gen(OP_J, 0, 0, 0); run_q(1000);
    chk("ret_after_bj", 32'(retired), 32'd4);
    // Illegal opcode after three idle FETCH cycles
    gen(6'b111111, 3, 0, 0); run_q(1000);
    chk("ret_after_ill", 32'(retired), 32'd4);
    // SW that times out, then SW that completes on the last allowed cycle
    gen(OP_SW, 0, 0, TO); run_q(1000);
    chk("ret_after_to", 32'(retired), 32'd4);
    gen(OP_SW, 0, 0, TO-1); run_q(1000);
    // Fetch timeout, then an ADDI
    gen(OP_ADDI, 0, TO, 0); gen(OP_ADDI, 0, 1, 0); run_q(1000);
    chk("ret_after_addi", 32'(retired), 32'd6);

    // Asynchronous reset in the middle of EXEC
    gen(OP_R, 0, 0, 0); run_q(2);
    @(negedge clk);
    chk("pre_rst_state", 32'(state_dbg), 32'd6);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state_dbg), 32'd0);
    chk("async_rst_retired", 32'(retired), 32'd0);
    chk("async_rst_regwrite", 32'(reg_write), 32'd0);
    q.delete();
    model_ret = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized instruction stream; long enough to wrap the counter
    for (int n = 0; n < 80; n++) begin
      gen(pick_op(), int'($urandom_range(0, 2)), pick_delay(), pick_delay());
      run_q(1000);
    end
    chk("ret_final", 32'(retired), 32'(model_ret));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath, which replaces single-cycle execution with one shared memory port and a shared ALU. It sequences fetch, decode, execute, memory and writeback for R_TYPE, ADDI, LW, SW, BEQ and J. It drives every datapath mux and write-enable signal and owns the req/ready handshake to the unified memory. It also counts retired instructions and detects memory timeouts.

Parameters:
CNT_W, 32, width of retired-instruction counter
MEM_TIMEOUT, 16, max cycles waiting for mem_ready in any memory state (>=1)

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
run  in  1  1 = allow new fetches
opcode  in  6  IR[31:26]; valid from DECODE onward
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  1 = write access
iord  out  1  address select: 0 = PC, 1 = ALUOut
ir_write  out  1  load IR
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sext imm, 11 = sext imm<<2
alu_op  out  2  00 = add, 01 = sub, 10 = use funct
reg_write  out  1  register file write enable
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = memory data, 0 = ALUOut
instr_done  out  1  1-cycle pulse, instruction retired
illegal_op  out  1  1-cycle pulse, unknown opcode
bus_err  out  1  1-cycle pulse, memory timeout
retired  out  CNT_W  retired count; wraps to 0
state_dbg  out  4  current state encoding

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, ADDI_EX=9, ADDI_WB=10, JUMP=11.
- Reset is asynchronous: state=FETCH, retired=0, timeout counter=0.
- All outputs are decoded from state (Moore), except ir_write, pc_write in FETCH, and the pulses. Any output not listed for a state is 0.
- During reset: mem_req=run, alu_src_b=01, and every other output is 0.
- FETCH: mem_req=run; iord=0; alu_src_a=0; alu_src_b=01; alu_op=00; pc_src=00.
  - ir_write = pc_write = run & mem_ready.
  - Stay while !(run & mem_ready); on run & mem_ready go to DECODE.
  - run=0 holds FETCH with no request.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precomputed into ALUOut). Next state by opcode:
  - LW (100011) or SW (101011) -> MEM_ADR
  - R_TYPE (000000) -> EXEC
  - BEQ (000100) -> BRANCH
  - ADDI (001000) -> ADDI_EX
  - J (000010) -> JUMP
  - any other opcode -> FETCH, illegal_op=1, not counted as retired.
- MEM_ADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_RD if opcode==LW, else MEM_WR.
- MEM_RD: mem_req=1, iord=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Wait for mem_ready, then go to FETCH (retire).
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01. Go to FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0. Go to FETCH.
- JUMP: pc_write=1, pc_src=10. Go to FETCH.
- Retirement:
  - instr_done pulses in the last cycle of each instruction: MEM_WB, MEM_WR with mem_ready, ALU_WB, BRANCH, ADDI_WB, JUMP.
  - retired increments on the same edge and wraps at 2^CNT_W.
- Latency with mem_ready tied to 1: LW=5, SW=4, R_TYPE=4, ADDI=4, BEQ=3, J=3 cycles.
- Handshake:
  - mem_req stays high and mem_we, iord stay stable until the mem_ready cycle.
  - mem_ready is ignored in non-memory states and in FETCH while run=0.
- Timeout:
  - The counter clears on entry to any memory state and increments each waiting cycle of FETCH (run=1), MEM_RD and MEM_WR.
  - If it reaches MEM_TIMEOUT without mem_ready: bus_err=1, state -> FETCH, no retire, no ir_write/pc_write.
  - mem_ready arriving in the same cycle as the timeout wins: normal completion, no bus_err.
- run=0 affects only FETCH; an instruction in flight always completes.

Test Plan:
- Reset: assert rst mid-EXEC -> state_dbg=0 immediately (async), retired=0, reg_write=0.
- R_TYPE, opcode=000000, mem_ready=1 -> states 0,1,6,7; reg_write=1 and reg_dst=1 in ALU_WB; instr_done once; retired=1 after 4 cycles.
- LW with mem_ready delayed 3 cycles in MEM_RD -> mem_req=1, iord=1 held 4 cycles; then MEM_WB with mem_to_reg=1; total 8 cycles.
- BEQ then J -> 3 cycles each; pc_write_cond=1 and pc_src=01 in state 8; pc_write=1 and pc_src=10 in state 11; retired=2.
- opcode=111111 -> DECODE then FETCH; illegal_op pulse; retired unchanged; run=0 holds FETCH with mem_req=0.
- MEM_TIMEOUT=4, SW with mem_ready=0 -> 4 wait cycles, bus_err pulse, back to FETCH, retired unchanged. Repeat with mem_ready on the 4th cycle -> instr_done, no bus_err.
